v_ch_ahb_writer: RTL
====================

# v_ch_ahb_writer

DMA channel write-side engine: drains a byte-lane channel FIFO and issues AHB-Lite single write transfers to the destination address range. It is the consumer end of the channel FIFO. Per beat it requests 2**size bytes from the FIFO at the destination lane offset, then places those bytes on HWDATA. One write transfer is outstanding at a time, and the block reports completion or bus error back to the channel controller.

## Interface
Parameters:
- LEN_W, 16, width of the byte-length field.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- areset  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse that starts a job; sampled only in IDLE.
- dst_addr_i  in  32  destination start byte address, sampled with start_i.
- len_i  in  LEN_W  job length in bytes, sampled with start_i.
- size_i  in  2  beat size: 0 = byte, 1 = halfword, 2 = word, 3 = illegal. Sampled with start_i.
- busy_o  out  1  high while a job is active.
- done_o  out  1  one-cycle pulse when a job completes successfully.
- err_o  out  1  one-cycle pulse on a rejected start or a bus error.
- fifo_level_i  in  8  bytes currently held in the channel FIFO.
- fifo_read_o  out  1  FIFO read strobe, one cycle per beat.
- fifo_size_o  out  2  FIFO read size; equals the latched size.
- fifo_offset_o  out  2  FIFO byte-lane offset; equals haddr[1:0] of the beat.
- fifo_data_i  in  32  FIFO lane-aligned read data, valid the cycle after fifo_read_o.
- haddr_o  out  32  AHB address.
- htrans_o  out  2  AHB transfer type; only IDLE (00) and NONSEQ (10) are used.
- hwrite_o  out  1  AHB write flag.
- hsize_o  out  3  AHB size, {1'b0, size}.
- hburst_o  out  3  AHB burst, constant 000 (SINGLE).
- hwdata_o  out  32  AHB write data.
- hready_i  in  1  AHB ready.
- hresp_i  in  1  AHB response; 1 = ERROR.

## Operation
- FSM states: IDLE, WAIT, FETCH, ADDR, DATA.
- IDLE, start_i high:
  - Reject the job if size_i == 3, or dst_addr_i is misaligned to 2**size_i, or len_i is not a multiple of 2**size_i. On reject, pulse err_o and stay in IDLE.
  - If len_i == 0, pulse done_o and stay in IDLE.
  - Otherwise latch addr, remaining = len_i and size, then go to WAIT.
- WAIT: when fifo_level_i >= 2**size, go to FETCH.
- FETCH: assert fifo_read_o for exactly one cycle, with fifo_offset_o = addr[1:0]. Go to ADDR.
- ADDR:
  - Drive htrans=NONSEQ, hwrite=1, haddr=addr, hsize.
  - In the first ADDR cycle, capture fifo_data_i into the wdata register.
  - When hready_i is high, go to DATA.
  - Address signals are held stable until hready_i is high.
- DATA:
  - Drive htrans=IDLE and hwdata_o = wdata register.
  - When hready_i is high and hresp_i is 0: addr += 2**size and remaining -= 2**size. If remaining == 0, pulse done_o and go to IDLE; otherwise go to WAIT.
  - When hresp_i is high (first error cycle, regardless of hready_i): pulse err_o, drive htrans IDLE, and go to IDLE. Remaining bytes are abandoned.
- Byte lanes: only lanes addr[1:0] .. addr[1:0]+2**size-1 of hwdata_o are meaningful. The other lanes carry whatever fifo_data_i presented (the FIFO returns zero there).
- Address arithmetic is a 32-bit wrap. remaining is LEN_W bits and never underflows because lengths are validated.
- busy_o is high in every state except IDLE.
- start_i is ignored while busy.
- areset in any state forces IDLE next cycle, clears all outputs, and abandons any AHB transfer in flight.

## Timing
- Reset values: busy_o, done_o, err_o, fifo_read_o = 0; htrans_o = 00; hwrite_o = 0; haddr_o = 0; hwdata_o = 0; fifo_size_o and fifo_offset_o = 0. hsize_o = 000; hburst_o = 000.
- start_i to first fifo_read_o: 2 cycles if FIFO level is sufficient (IDLE→WAIT→FETCH).
- Beat cost: 4 cycles minimum with zero wait states (WAIT, FETCH, ADDR, DATA). Each hready_i-low cycle adds one cycle in ADDR or DATA.
- done_o is asserted in the cycle after the last DATA handshake; busy_o falls in the same cycle.
- hwdata_o is stable for all of DATA.
- The FIFO is never read again before the current beat completes.

## Test plan
- Word job, dst 0x1000, len 8, hready always 1, FIFO full → two NONSEQ writes at 0x1000 and 0x1004. Word offset 0. done_o pulses 9 cycles after start.
- Byte job, dst 0x2003, len 3 → haddr 0x2003, 0x2004, 0x2005 with hsize 000. fifo_offset_o is 3, 0, 1, and lane data matches the offset.
- Halfword job, dst 0x0002, len 4, hready low 2 cycles in ADDR and 1 in DATA → address held stable; beat 1 takes 7 cycles; done_o after 2 beats.
- FIFO starvation: fifo_level_i = 1 with size=word → stays in WAIT with no fifo_read_o. Raising the level to 4 → FETCH on the next cycle.
- Bad start: dst 0x1001 with word size, or len 6 with word size, or size 3 → err_o pulse, busy_o stays 0, no AHB activity. len 0 → done_o pulse only.
- hresp_i=1 during DATA of beat 2 of 4 → err_o pulse, IDLE, no further FIFO reads. areset in ADDR → htrans 00 and busy 0 on the next cycle.

Source files
------------

// File: rtl/v_ch_ahb_writer.sv
// v_ch_ahb_writer
//   DMA channel write-side engine. Drains the byte-lane channel FIFO one beat
//   at a time and issues AHB-Lite SINGLE write transfers, with one transfer
//   outstanding at a time. Reports completion or errors to the channel
//   controller.
//
// Ports
//   clk, areset        clock, synchronous active-high reset
//   start_i            one-cycle job start (only honoured in IDLE)
//   dst_addr_i         destination start byte address
//   len_i              job length in bytes
//   size_i             beat size (0 byte, 1 halfword, 2 word, 3 illegal)
//   busy_o             job active
//   done_o             one-cycle pulse on successful completion
//   err_o              one-cycle pulse on rejected start or bus error
//   fifo_level_i       bytes held in the channel FIFO
//   fifo_read_o        FIFO read strobe, one per beat
//   fifo_size_o        FIFO read size (latched beat size)
//   fifo_offset_o      FIFO byte-lane offset (haddr[1:0] of the beat)
//   fifo_data_i        lane-aligned FIFO data, valid the cycle after the read
//   haddr_o .. hburst_o AHB-Lite master address/control
//   hwdata_o           AHB write data
//   hready_i, hresp_i  AHB-Lite slave response
module v_ch_ahb_writer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [1:0]       size_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [7:0]       fifo_level_i,
  output logic             fifo_read_o,
  output logic [1:0]       fifo_size_o,
  output logic [1:0]       fifo_offset_o,
  input  logic [31:0]      fifo_data_i,
  output logic [31:0]      haddr_o,
  output logic [1:0]       htrans_o,
  output logic             hwrite_o,
  output logic [2:0]       hsize_o,
  output logic [2:0]       hburst_o,
  output logic [31:0]      hwdata_o,
  input  logic             hready_i,
  input  logic             hresp_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_ADDR,
    S_DATA
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] rem_q;
  logic [1:0]       size_q;
  logic [31:0]      wdata_q;
  logic             first_q;
  logic             done_q;
  logic             err_q;

  logic [2:0]       beat_bytes;
  logic [1:0]       start_mask;
  logic             start_bad;
  logic             last_beat;

  always_comb begin
    case (size_q)
      2'd0:    beat_bytes = 3'd1;
      2'd1:    beat_bytes = 3'd2;
      default: beat_bytes = 3'd4;
    endcase
  end

  // Low-bit mask that must be clear in both address and length for a
  // naturally aligned job of the requested beat size.
  always_comb begin
    case (size_i)
      2'd0:    start_mask = 2'b00;
      2'd1:    start_mask = 2'b01;
      default: start_mask = 2'b11;
    endcase
  end

  assign start_bad = (size_i == 2'd3)
                   || ((dst_addr_i[1:0] & start_mask) != 2'b00)
                   || ((len_i[1:0] & start_mask) != 2'b00);

  assign last_beat = (rem_q == LEN_W'(beat_bytes));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !start_bad && (len_i != '0)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fifo_level_i >= {5'b0, beat_bytes}) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_ADDR;
      S_ADDR: begin
        if (hready_i) state_d = S_DATA;
      end
      S_DATA: begin
        if (hresp_i)        state_d = S_IDLE;
        else if (hready_i)  state_d = last_beat ? S_IDLE : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // FIFO data arrives the cycle after the strobe, i.e. the first ADDR cycle.
      first_q <= (state_q == S_FETCH);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (start_bad) begin
              err_q <= 1'b1;
            end else if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q <= dst_addr_i;
              rem_q  <= len_i;
              size_q <= size_i;
            end
          end
        end
        S_ADDR: begin
          if (first_q) wdata_q <= fifo_data_i;
        end
        S_DATA: begin
          if (hresp_i) begin
            err_q <= 1'b1;
          end else if (hready_i) begin
            addr_q <= addr_q + 32'(beat_bytes);
            rem_q  <= rem_q - LEN_W'(beat_bytes);
            if (last_beat) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign fifo_read_o   = (state_q == S_FETCH);
  assign fifo_size_o   = size_q;
  assign fifo_offset_o = addr_q[1:0];
  assign haddr_o       = addr_q;
  assign htrans_o      = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign hwrite_o      = (state_q == S_ADDR);
  assign hsize_o       = {1'b0, size_q};
  assign hburst_o      = 3'b000;
  assign hwdata_o      = wdata_q;

endmodule
